// File: rtl/apb_spi_pkg.sv
// Register map, bit indices and engine state encoding shared by the apb_spi_master files.
package apb_spi_pkg;

  localparam logic [2:0] OffCr       = 3'd0;
  localparam logic [2:0] OffPresc    = 3'd1;
  localparam logic [2:0] OffIrqEn    = 3'd2;
  localparam logic [2:0] OffIrq      = 3'd3;
  localparam logic [2:0] OffDataTx   = 3'd4;
  localparam logic [2:0] OffDataRx   = 3'd5;
  localparam logic [2:0] OffSr       = 3'd6;
  localparam logic [2:0] OffUnmapped = 3'd7;

  localparam int unsigned CrSpien   = 0;
  localparam int unsigned CrFlushRx = 1;
  localparam int unsigned CrFlushTx = 2;

  localparam int unsigned IrqTrxDone = 0;
  localparam int unsigned IrqTxFull  = 1;

  typedef enum logic [1:0] {StIdle, StLoad, StShift} spi_state_e;

endpackage

// File: rtl/apb_spi_fifo.sv
// Synchronous show-ahead FIFO; flush is a level that holds the FIFO empty.
module apb_spi_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8,
  parameter int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_wdata,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [Width-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CntW-1:0]  o_count
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr, r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_push, w_pop;

  assign w_pop  = i_pop & (r_count != '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign w_push = i_push & ((r_count != CntW'(Depth)) | w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_count == CntW'(Depth));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/apb_spi_master.sv
// APB3 slave driving a mode-0, MSB-first, 8-bit SPI master with TX/RX FIFOs and a level IRQ.
// Define APBSPI_PSLVERR_EN to report error responses on pslverr.
module apb_spi_master
  import apb_spi_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                      i_pclk,
  input  logic                      i_preset,
  input  logic [APB_ADDR_WIDTH-1:0] i_paddr,
  input  logic                      i_psel,
  input  logic                      i_penable,
  input  logic                      i_pwrite,
  input  logic [31:0]               i_pwdata,
  output logic [31:0]               o_prdata,
  output logic                      o_pready,
  output logic                      o_pslverr,
  output logic                      o_sclk,
  output logic                      o_mosi,
  input  logic                      i_miso,
  output logic                      o_cs_n,
  output logic                      o_irq
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]  w_off;
  logic        w_acc, w_wr, w_rd;
  logic [2:0]  r_cr;
  logic [15:0] r_presc;
  logic [1:0]  r_irq_en, r_irq, w_irq_nxt;

  logic            w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_avail, w_tx_fill;
  logic [7:0]      w_tx_rdata, w_rx_rdata;
  logic [CntW-1:0] w_tx_count, w_rx_count;
  logic            w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;

  spi_state_e  r_state, w_state_nxt;
  logic [15:0] r_div, w_div_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [7:0]  r_tx, w_tx_nxt, r_rx, w_rx_nxt;
  logic        r_sclk, w_sclk_nxt, r_mosi, w_mosi_nxt, r_cs_n, w_cs_n_nxt, w_done;

  assign w_off      = i_paddr[4:2];
  assign w_acc      = i_psel & i_penable;
  assign w_wr       = w_acc & i_pwrite;
  assign w_rd       = w_acc & ~i_pwrite;
  assign w_tx_push  = w_wr & (w_off == OffDataTx) & ~w_tx_full;
  assign w_rx_pop   = w_rd & (w_off == OffDataRx) & ~w_rx_empty;
  assign w_tx_avail = ~w_tx_empty & ~r_cr[CrFlushTx];
  // TX_FULL fires on the push that takes the FIFO to its last free slot.
  assign w_tx_fill  = w_tx_push & ~w_tx_pop & ~r_cr[CrFlushTx] &
                      (w_tx_count == CntW'(FIFO_DEPTH - 1));

  apb_spi_fifo #(.Depth(FIFO_DEPTH), .Width(8)) u_tx_fifo (
    .i_clk(i_pclk), .i_rst(i_preset), .i_push(w_tx_push), .i_wdata(i_pwdata[7:0]),
    .i_pop(w_tx_pop), .i_flush(r_cr[CrFlushTx]), .o_rdata(w_tx_rdata), .o_full(w_tx_full),
    .o_empty(w_tx_empty), .o_count(w_tx_count)
  );

  apb_spi_fifo #(.Depth(FIFO_DEPTH), .Width(8)) u_rx_fifo (
    .i_clk(i_pclk), .i_rst(i_preset), .i_push(w_rx_push), .i_wdata(r_rx),
    .i_pop(w_rx_pop), .i_flush(r_cr[CrFlushRx]), .o_rdata(w_rx_rdata), .o_full(w_rx_full),
    .o_empty(w_rx_empty), .o_count(w_rx_count)
  );

  // Hardware set wins over a simultaneous clear-write.
  always_comb begin
    w_irq_nxt = r_irq;
    if (w_wr && (w_off == OffIrq)) w_irq_nxt = r_irq & i_pwdata[1:0];
    if (w_done)    w_irq_nxt[IrqTrxDone] = 1'b1;
    if (w_tx_fill) w_irq_nxt[IrqTxFull]  = 1'b1;
  end

  always_ff @(posedge i_pclk or posedge i_preset) begin
    if (i_preset) begin
      r_cr     <= '0;
      r_presc  <= '0;
      r_irq_en <= '0;
      r_irq    <= '0;
    end else begin
      r_irq <= w_irq_nxt;
      if (w_wr) begin
        case (w_off)
          OffCr:    r_cr     <= i_pwdata[2:0];
          OffPresc: r_presc  <= i_pwdata[15:0];
          OffIrqEn: r_irq_en <= i_pwdata[1:0];
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    o_prdata = '0;
    if (i_psel && !i_pwrite) begin
      case (w_off)
        OffCr:     o_prdata[2:0]  = r_cr;
        OffPresc:  o_prdata[15:0] = r_presc;
        OffIrqEn:  o_prdata[1:0]  = r_irq_en;
        OffIrq:    o_prdata[1:0]  = r_irq;
        OffDataRx: if (!w_rx_empty) o_prdata[7:0] = w_rx_rdata;
        OffSr:     o_prdata[4:0]  = {r_state != StIdle, w_rx_full, w_rx_empty, w_tx_full,
                                     w_tx_empty};
        default:   ;
      endcase
    end
  end

`ifdef APBSPI_PSLVERR_EN
  assign o_pslverr = w_acc & ((w_off == OffUnmapped) |
                              (i_pwrite & (w_off == OffDataTx) & w_tx_full) |
                              (~i_pwrite & (w_off == OffDataRx) & w_rx_empty));
`else
  assign o_pslverr = 1'b0;
`endif

  // Engine: each SHIFT half-period lasts PRESC+1 cycles; rise samples miso, fall moves mosi.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_tx_nxt    = r_tx;
    w_rx_nxt    = r_rx;
    w_sclk_nxt  = r_sclk;
    w_mosi_nxt  = r_mosi;
    w_cs_n_nxt  = r_cs_n;
    w_tx_pop    = 1'b0;
    w_rx_push   = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_cr[CrSpien] && w_tx_avail) begin
          w_tx_pop    = 1'b1;
          w_tx_nxt    = w_tx_rdata;
          w_mosi_nxt  = w_tx_rdata[7];
          w_cs_n_nxt  = 1'b0;
          w_state_nxt = StLoad;
        end
      end
      StLoad: begin
        w_div_nxt   = '0;
        w_bit_nxt   = '0;
        w_state_nxt = StShift;
      end
      StShift: begin
        if (r_div != r_presc) begin
          w_div_nxt = r_div + 16'd1;
        end else begin
          w_div_nxt  = '0;
          w_sclk_nxt = ~r_sclk;
          if (!r_sclk) begin
            w_rx_nxt = {r_rx[6:0], i_miso};
          end else if (r_bit != 3'd7) begin
            w_bit_nxt  = r_bit + 3'd1;
            w_tx_nxt   = {r_tx[6:0], 1'b0};
            w_mosi_nxt = r_tx[6];
          end else begin
            w_rx_push = 1'b1;
            if (r_cr[CrSpien] && w_tx_avail) begin
              w_tx_pop    = 1'b1;
              w_tx_nxt    = w_tx_rdata;
              w_mosi_nxt  = w_tx_rdata[7];
              w_state_nxt = StLoad;
            end else begin
              w_cs_n_nxt  = 1'b1;
              w_mosi_nxt  = 1'b0;
              w_done      = 1'b1;
              w_state_nxt = StIdle;
            end
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_pclk or posedge i_preset) begin
    if (i_preset) begin
      r_state <= StIdle;
      r_div   <= '0;
      r_bit   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
      r_rx    <= w_rx_nxt;
      r_sclk  <= w_sclk_nxt;
      r_mosi  <= w_mosi_nxt;
      r_cs_n  <= w_cs_n_nxt;
    end
  end

  assign o_pready = 1'b1;
  assign o_sclk   = r_sclk;
  assign o_mosi   = r_mosi;
  assign o_cs_n   = r_cs_n;
  assign o_irq    = |(r_irq & r_irq_en);

  logic w_unused;
  assign w_unused = ^{i_paddr[APB_ADDR_WIDTH-1:5], i_paddr[1:0], i_pwdata[31:16], w_rx_count};

endmodule

// File: tb/tb_apb_spi_master.sv
// Randomized self-checking bench for apb_spi_master with a behavioural SPI slave and FIFO model.
module tb_apb_spi_master;

  localparam logic [31:0] AddrCr = 32'h00, AddrPresc = 32'h04, AddrIrqEn = 32'h08;
  localparam logic [31:0] AddrIrq = 32'h0C, AddrTx = 32'h10, AddrRx = 32'h14;
  localparam logic [31:0] AddrSr = 32'h18, AddrUnm = 32'h1C;
`ifdef APBSPI_PSLVERR_EN
  localparam logic [31:0] ExpErr = 32'd1;
`else
  localparam logic [31:0] ExpErr = 32'd0;
`endif

  logic        pclk = 1'b0, preset = 1'b1;
  logic [31:0] paddr = '0, pwdata = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] prdata;
  logic        pready, pslverr, sclk, mosi, miso, cs_n, irq;

  apb_spi_master u_dut (
    .i_pclk(pclk), .i_preset(preset), .i_paddr(paddr), .i_psel(psel), .i_penable(penable),
    .i_pwrite(pwrite), .i_pwdata(pwdata), .o_prdata(prdata), .o_pready(pready),
    .o_pslverr(pslverr), .o_sclk(sclk), .o_mosi(mosi), .i_miso(miso), .o_cs_n(cs_n),
    .o_irq(irq)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0, n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural SPI slave and mosi monitor; the slave shifts out sl_data[sl_idx] each frame.
  logic [7:0] sl_data [256];
  logic [7:0] sl_idx = '0;
  logic       loopback = 1'b0;
  int         fr_bit = 0, n_rise = 0, n_cs_fall = 0;
  logic [7:0] mon_sh = '0;
  logic [7:0] q_mosi [$];

  always_comb begin
    logic [7:0] cur;
    cur  = sl_data[sl_idx];
    miso = loopback ? mosi : cur[3'(7 - fr_bit)];
  end

  always @(posedge sclk or posedge cs_n) begin
    if (cs_n) begin
      fr_bit <= 0;
    end else begin
      n_rise <= n_rise + 1;
      mon_sh <= {mon_sh[6:0], mosi};
      if (fr_bit == 7) begin
        q_mosi.push_back({mon_sh[6:0], mosi});
        fr_bit <= 0;
        sl_idx <= sl_idx + 8'd1;
      end else begin
        fr_bit <= fr_bit + 1;
      end
    end
  end

  always @(negedge cs_n) n_cs_fall <= n_cs_fall + 1;

  // Reference model: pending TX bytes, expected mosi stream and expected RX FIFO contents.
  logic [7:0] m_tx [$];
  logic [7:0] exp_mosi [$];
  logic [7:0] q_rx_exp [$];
  logic [7:0] m_sl = '0;
  int         mchk = 0;
  logic       last_err;

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge pclk);
    penable = 1'b1;
    #1 last_err = pslverr;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge pclk);
    penable = 1'b1;
    #1 d = prdata;
    last_err = pslverr;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(a, d);
    check_eq(tag, d, exp);
  endtask

  task automatic push_tx(input logic [7:0] b);
    apb_write(AddrTx, {24'b0, b});
    if (m_tx.size() < 8) m_tx.push_back(b);
  endtask

  task automatic drain_model();
    logic [7:0] b, r;
    while (m_tx.size() > 0) begin
      b = m_tx.pop_front();
      exp_mosi.push_back(b);
      r = loopback ? b : sl_data[m_sl];
      m_sl = m_sl + 8'd1;
      if (q_rx_exp.size() < 8) q_rx_exp.push_back(r);
    end
  endtask

  task automatic read_rx(input string tag);
    logic [31:0] exp;
    exp = (q_rx_exp.size() > 0) ? {24'b0, q_rx_exp.pop_front()} : 32'd0;
    check_rd(tag, AddrRx, exp);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] sr;
    int n = 0;
    do begin
      apb_read(AddrSr, sr);
      n++;
    end while (!(sr[0] && !sr[4]) && n < 4000);
    check_eq({tag, " idle"}, {31'b0, sr[0] && !sr[4]}, 32'd1);
    drain_model();
  endtask

  task automatic verify_mosi(input string tag);
    check_eq({tag, " frames"}, q_mosi.size(), exp_mosi.size());
    for (int i = mchk; i < q_mosi.size() && i < exp_mosi.size(); i++)
      check_eq($sformatf("%s mosi[%0d]", tag, i), {24'b0, q_mosi[i]}, {24'b0, exp_mosi[i]});
    mchk = exp_mosi.size();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0, c0, n, k;
    logic [7:0] b;
    for (int i = 0; i < 256; i++) sl_data[i] = 8'($urandom);

    repeat (3) @(negedge pclk);
    #1;
    check_eq("rst cs_n", {31'b0, cs_n}, 32'd1);
    check_eq("rst sclk", {31'b0, sclk}, 32'd0);
    check_eq("rst mosi", {31'b0, mosi}, 32'd0);
    check_eq("rst irq", {31'b0, irq}, 32'd0);
    check_eq("rst prdata", prdata, 32'd0);
    check_eq("rst pslverr", {31'b0, pslverr}, 32'd0);
    preset = 1'b0;
    check_rd("rst CR", AddrCr, 32'd0);
    check_rd("rst PRESC", AddrPresc, 32'd0);
    check_rd("rst IRQ_EN", AddrIrqEn, 32'd0);
    check_rd("rst IRQ", AddrIrq, 32'd0);
    check_rd("rst SR", AddrSr, 32'h5);
    check_rd("rst DATA_RX", AddrRx, 32'd0);

    apb_write(AddrPresc, 32'd1);
    apb_write(AddrCr, 32'd1);
    apb_write(AddrIrqEn, 32'd3);
    check_rd("PRESC rb", AddrPresc, 32'd1);
    check_rd("CR rb", AddrCr, 32'd1);
    check_rd("IRQ_EN rb", AddrIrqEn, 32'd3);

    // Single loopback frame.
    loopback = 1'b1;
    r0 = n_rise; c0 = n_cs_fall;
    push_tx(8'hA5);
    wait_idle("a5");
    verify_mosi("a5");
    check_eq("a5 sclk rises", n_rise - r0, 32'd8);
    check_eq("a5 cs frames", n_cs_fall - c0, 32'd1);
    read_rx("a5 DATA_RX");
    check_rd("a5 IRQ", AddrIrq, 32'd1);
    check_eq("a5 irq", {31'b0, irq}, 32'd1);
    loopback = 1'b0;

    apb_write(AddrIrq, 32'd0);
    check_eq("irq cleared", {31'b0, irq}, 32'd0);
    check_rd("IRQ cleared", AddrIrq, 32'd0);

    // Fill TX while disabled, then release as one back-to-back burst.
    apb_write(AddrCr, 32'd0);
    for (int i = 0; i < 8; i++) push_tx(8'($urandom));
    check_rd("full IRQ", AddrIrq, 32'd2);
    check_eq("full irq", {31'b0, irq}, 32'd1);
    push_tx(8'($urandom));
    check_eq("full push err", {31'b0, last_err}, ExpErr);
    check_rd("full SR", AddrSr, 32'h6);
    apb_write(AddrIrq, 32'd0);
    r0 = n_rise; c0 = n_cs_fall;
    apb_write(AddrCr, 32'd1);
    wait_idle("b2b");
    verify_mosi("b2b");
    check_eq("b2b sclk rises", n_rise - r0, 32'd64);
    check_eq("b2b cs frames", n_cs_fall - c0, 32'd1);
    check_rd("b2b IRQ", AddrIrq, 32'd1);
    push_tx(8'($urandom));
    wait_idle("rxfull");
    verify_mosi("rxfull");
    for (int i = 0; i < 8; i++) read_rx($sformatf("rxfull rx%0d", i));
    read_rx("rxfull empty rd");
    check_eq("rx empty err", {31'b0, last_err}, ExpErr);
    check_rd("rxfull SR", AddrSr, 32'h5);

    // Slave returns 0x3C on three frames.
    for (int i = 0; i < 3; i++) sl_data[8'(m_sl + 8'(i))] = 8'h3C;
    for (int i = 0; i < 3; i++) push_tx(8'($urandom));
    wait_idle("3c");
    verify_mosi("3c");
    for (int i = 0; i < 3; i++) check_rd($sformatf("3c rx%0d", i), AddrRx, 32'h3C);
    void'(q_rx_exp.pop_front()); void'(q_rx_exp.pop_front()); void'(q_rx_exp.pop_front());
    read_rx("3c empty rd");
    check_rd("3c SR", AddrSr, 32'h5);

    for (int it = 0; it < 6; it++) begin
      apb_write(AddrPresc, $urandom_range(0, 3));
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) push_tx(8'($urandom));
      wait_idle($sformatf("rnd%0d", it));
      verify_mosi($sformatf("rnd%0d", it));
      for (int i = 0; i < n; i++) read_rx($sformatf("rnd%0d rx%0d", it, i));
    end

    // Flush levels on both FIFOs.
    push_tx(8'($urandom));
    push_tx(8'($urandom));
    wait_idle("flush");
    verify_mosi("flush");
    check_rd("pre-flush SR", AddrSr, 32'h1);
    apb_write(AddrCr, 32'd3);
    q_rx_exp.delete();
    check_rd("flush_rx SR", AddrSr, 32'h5);
    apb_write(AddrCr, 32'd1);
    read_rx("flushed rx");
    apb_write(AddrCr, 32'd0);
    for (int i = 0; i < 3; i++) push_tx(8'($urandom));
    check_rd("pre-flush_tx SR", AddrSr, 32'h4);
    apb_write(AddrCr, 32'd4);
    m_tx.delete();
    check_rd("flush_tx SR", AddrSr, 32'h5);
    apb_write(AddrCr, 32'd0);

    apb_write(AddrUnm, 32'hFFFF_FFFF);
    check_eq("unmapped wr err", {31'b0, last_err}, ExpErr);
    check_rd("unmapped rd", AddrUnm, 32'd0);
    check_eq("unmapped rd err", {31'b0, last_err}, ExpErr);
    check_rd("DATA_TX rd", AddrTx, 32'd0);

    // Reset in the middle of a frame.
    apb_write(AddrPresc, 32'd3);
    apb_write(AddrCr, 32'd1);
    b = 8'($urandom);
    apb_write(AddrTx, {24'b0, b});
    k = 0;
    while (cs_n && k < 200) begin
      @(negedge pclk);
      k++;
    end
    check_eq("midrst frame started", {31'b0, cs_n}, 32'd0);
    repeat (20) @(negedge pclk);
    preset = 1'b1;
    #1;
    check_eq("midrst cs_n", {31'b0, cs_n}, 32'd1);
    check_eq("midrst sclk", {31'b0, sclk}, 32'd0);
    check_eq("midrst mosi", {31'b0, mosi}, 32'd0);
    @(negedge pclk);
    preset = 1'b0;
    check_rd("midrst CR", AddrCr, 32'd0);
    check_rd("midrst PRESC", AddrPresc, 32'd0);
    check_rd("midrst SR", AddrSr, 32'h5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
